// File: rtl/rgb_matrix_pkg.sv
// rtl/rgb_matrix_pkg.sv - shared types, defaults and helpers for the RGB matrix shift receiver
// Contents: default word width and column count, colour field offsets,
// col_word_t, frame FSM state type, onehot_to_idx (index + valid).
package rgb_matrix_pkg;

  localparam int DEF_SHIFT_W = 24;
  localparam int DEF_COLS    = 8;

  // Colour fields inside one column word (red shifted out first).
  localparam int RED_HI   = 23;
  localparam int RED_LO   = 16;
  localparam int GREEN_HI = 15;
  localparam int GREEN_LO = 8;
  localparam int BLUE_HI  = 7;
  localparam int BLUE_LO  = 0;

  typedef logic [DEF_SHIFT_W-1:0] col_word_t;

  typedef enum logic {
    ST_IDLE,
    ST_COLLECT
  } frame_state_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] idx;
  } onehot_idx_t;

  // Works on up to 32 columns; callers zero-extend their select vector.
  function automatic onehot_idx_t onehot_to_idx(input logic [31:0] v);
    onehot_idx_t r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (v[i]) r.idx = 5'(i);
    end
    r.valid = (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
    return r;
  endfunction

endpackage

// File: rtl/link_sync.sv
// rtl/link_sync.sv - multi-stage synchroniser with rising-edge detect for one link clock
// Ports: clk, rst_n (async active-low), d (raw pin), rise (one-cycle pulse
// when the synchronised level goes 0 -> 1).
module link_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // Combinational so the consuming register updates SYNC_STAGES+1 cycles after the pin.
  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/rgb_matrix_shift_receiver.sv
// rtl/rgb_matrix_shift_receiver.sv - board-side model of the 595-style RGB column link
// Ports: clk, reset (async active-low); link pins reset_out, OE, SH_CP, ST_CP,
// DS, col_select; readback rd_col -> rd_data (registered); shift_q/store_q
// register images; display_on; frame_done pulse; sticky err_onehot/err_count.
module rgb_matrix_shift_receiver
  import rgb_matrix_pkg::*;
#(
  parameter int SHIFT_W     = DEF_SHIFT_W,
  parameter int COLS        = DEF_COLS,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     reset_out,
  input  logic                     OE,
  input  logic                     SH_CP,
  input  logic                     ST_CP,
  input  logic                     DS,
  input  logic [COLS-1:0]          col_select,
  input  logic [$clog2(COLS)-1:0]  rd_col,
  output logic [SHIFT_W-1:0]       rd_data,
  output logic [SHIFT_W-1:0]       shift_q,
  output logic [SHIFT_W-1:0]       store_q,
  output logic                     display_on,
  output logic                     frame_done,
  output logic                     err_onehot,
  output logic                     err_count
);

  localparam int IDX_W  = $clog2(COLS);
  localparam int CNT_W  = $clog2(SHIFT_W + 2);
  localparam int PIPE_W = COLS + 3;

  // Level-only synchroniser for data, column and control levels.
  logic [SYNC_STAGES-1:0][PIPE_W-1:0] pipe_q;
  logic [COLS-1:0]                    col_s;
  logic                               ds_s, oe_s, rst_out_s;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pipe_q <= '0;
    else        pipe_q <= {pipe_q[SYNC_STAGES-2:0], {col_select, DS, OE, reset_out}};
  end

  assign {col_s, ds_s, oe_s, rst_out_s} = pipe_q[SYNC_STAGES-1];

  logic sh_rise, st_rise;

  link_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sh_sync (
    .clk  (clk),
    .rst_n(reset),
    .d    (SH_CP),
    .rise (sh_rise)
  );

  link_sync #(.SYNC_STAGES(SYNC_STAGES)) u_st_sync (
    .clk  (clk),
    .rst_n(reset),
    .d    (ST_CP),
    .rise (st_rise)
  );

  assign display_on = ~oe_s & rst_out_s;

  onehot_idx_t      col_oh;
  logic [IDX_W-1:0] col_idx;
  logic             latch_ok;
  logic             unused_idx_bits;

  assign col_oh          = onehot_to_idx(32'(col_s));
  assign col_idx         = col_oh.idx[IDX_W-1:0];
  assign latch_ok        = st_rise & col_oh.valid;
  assign unused_idx_bits = ^col_oh.idx;

  // Shift stage and bit counter; a coincident store+shift leaves the counter at 1.
  logic [CNT_W-1:0] bit_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift_q <= '0;
      bit_cnt <= '0;
    end else if (!rst_out_s) begin
      shift_q <= '0;
      bit_cnt <= '0;
    end else begin
      if (sh_rise) shift_q <= {shift_q[SHIFT_W-2:0], ds_s};
      if (st_rise && sh_rise)
        bit_cnt <= CNT_W'(1);
      else if (st_rise)
        bit_cnt <= '0;
      else if (sh_rise && bit_cnt != CNT_W'(SHIFT_W + 1))
        bit_cnt <= bit_cnt + CNT_W'(1);
    end
  end

  // Storage stage, frame buffer and sticky protocol flags.
  logic [SHIFT_W-1:0] frame_q [COLS];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      store_q    <= '0;
      err_count  <= 1'b0;
      err_onehot <= 1'b0;
      for (int i = 0; i < COLS; i++) frame_q[i] <= '0;
    end else if (st_rise) begin
      store_q <= shift_q;
      if (bit_cnt != CNT_W'(SHIFT_W)) err_count <= 1'b1;
      if (col_oh.valid) frame_q[col_idx] <= shift_q;
      else              err_onehot <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rd_data <= '0;
    else if (int'(rd_col) < COLS) rd_data <= frame_q[rd_col];
    else rd_data <= '0;
  end

  // Frame tracking: collect column bits until every column has been latched.
  frame_state_t    state_q, state_d;
  logic [COLS-1:0] col_mask, mask_d, mask_set;
  logic            done_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      col_mask   <= '0;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_mask   <= mask_d;
      frame_done <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    mask_d   = col_mask;
    done_d   = 1'b0;
    mask_set = col_mask;
    if (latch_ok) mask_set[col_idx] = 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (latch_ok) begin
          state_d = ST_COLLECT;
          mask_d  = mask_set;
        end
      end
      ST_COLLECT: mask_d = mask_set;
      default:    state_d = ST_IDLE;
    endcase
    // Completion clears the mask on the latch edge; the pulse follows one cycle later.
    if (&mask_d) begin
      done_d  = 1'b1;
      mask_d  = '0;
      state_d = ST_IDLE;
    end
  end

endmodule

// File: tb/tb_rgb_matrix_shift_receiver.sv
// tb/tb_rgb_matrix_shift_receiver.sv - randomized self-checking bench for rgb_matrix_shift_receiver
module tb_rgb_matrix_shift_receiver;
  import rgb_matrix_pkg::*;

  localparam int W    = DEF_SHIFT_W;
  localparam int NC   = DEF_COLS;
  localparam int SS   = 2;
  localparam int HOLD = SS + 2;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          reset_out = 1'b0;
  logic          OE = 1'b1;
  logic          SH_CP = 1'b0;
  logic          ST_CP = 1'b0;
  logic          DS = 1'b0;
  logic [NC-1:0] col_select = '0;
  logic [2:0]    rd_col = '0;
  logic [W-1:0]  rd_data, shift_q, store_q;
  logic          display_on, frame_done, err_onehot, err_count;

  rgb_matrix_shift_receiver #(.SHIFT_W(W), .COLS(NC), .SYNC_STAGES(SS)) dut (
    .clk(clk), .reset(reset), .reset_out(reset_out), .OE(OE),
    .SH_CP(SH_CP), .ST_CP(ST_CP), .DS(DS), .col_select(col_select),
    .rd_col(rd_col), .rd_data(rd_data), .shift_q(shift_q), .store_q(store_q),
    .display_on(display_on), .frame_done(frame_done),
    .err_onehot(err_onehot), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int done_seen = 0;
  int done_exp = 0;

  always @(negedge clk) if (frame_done) done_seen++;

  // Reference model: register images tracked per link event.
  col_word_t     m_shift, m_store;
  col_word_t     m_frame [NC];
  int            m_cnt;
  logic [NC-1:0] m_mask;
  logic          m_eoh, m_ecnt;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_shift = '0; m_store = '0; m_cnt = 0; m_mask = '0; m_eoh = 1'b0; m_ecnt = 1'b0;
    for (int c = 0; c < NC; c++) m_frame[c] = '0;
  endtask

  task automatic model_shift(input logic b);
    m_shift = col_word_t'((m_shift << 1) | col_word_t'(b));
    m_cnt   = (m_cnt < W + 1) ? m_cnt + 1 : W + 1;
  endtask

  task automatic model_store(input logic [NC-1:0] col);
    m_store = m_shift;
    if (m_cnt != W) m_ecnt = 1'b1;
    m_cnt = 0;
    if ($countones(col) == 1) begin
      for (int c = 0; c < NC; c++) begin
        if (col[c]) begin
          m_frame[c] = m_shift;
          m_mask[c]  = 1'b1;
        end
      end
      if (m_mask == {NC{1'b1}}) begin
        done_exp++;
        m_mask = '0;
      end
    end else begin
      m_eoh = 1'b1;
    end
  endtask

  task automatic shift_bit(input logic b);
    DS = b;
    wait_cyc(HOLD);
    SH_CP = 1'b1;
    model_shift(b);
    wait_cyc(HOLD);
    SH_CP = 1'b0;
  endtask

  task automatic shift_word(input logic [31:0] val, input int n);
    for (int i = n - 1; i >= 0; i--) shift_bit(val[i]);
  endtask

  task automatic latch(input logic [NC-1:0] col);
    col_select = col;
    wait_cyc(HOLD);
    ST_CP = 1'b1;
    model_store(col);
    wait_cyc(HOLD);
    ST_CP = 1'b0;
    wait_cyc(HOLD);
  endtask

  task automatic clear_link();
    reset_out = 1'b0;
    wait_cyc(4);
    m_shift = '0;
    m_cnt = 0;
    reset_out = 1'b1;
    wait_cyc(HOLD);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    wait_cyc(2);
    reset = 1'b1;
    model_reset();
    wait_cyc(HOLD);
  endtask

  task automatic check_state(input string tag);
    check_eq({tag, ".shift_q"}, 32'(shift_q), 32'(m_shift));
    check_eq({tag, ".store_q"}, 32'(store_q), 32'(m_store));
    check_eq({tag, ".err_count"}, 32'(err_count), 32'(m_ecnt));
    check_eq({tag, ".err_onehot"}, 32'(err_onehot), 32'(m_eoh));
    check_eq({tag, ".frame_done"}, 32'(done_seen), 32'(done_exp));
    check_eq({tag, ".col_mask"}, 32'(dut.col_mask), 32'(m_mask));
    for (int c = 0; c < NC; c++) begin
      rd_col = 3'(c);
      wait_cyc(1);
      check_eq($sformatf("%s.rd%0d", tag, c), 32'(rd_data), 32'(m_frame[c]));
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0]   word;
    logic [NC-1:0] col;
    int            r, n;

    model_reset();
    wait_cyc(3);
    check_eq("rst.shift_q", 32'(shift_q), 32'd0);
    check_eq("rst.store_q", 32'(store_q), 32'd0);
    check_eq("rst.rd_data", 32'(rd_data), 32'd0);
    check_eq("rst.outs", {28'd0, display_on, frame_done, err_onehot, err_count}, 32'd0);
    reset = 1'b1;
    reset_out = 1'b1;
    wait_cyc(HOLD);

    // Reset mid-frame: three columns latched, then a one-cycle reset.
    for (int c = 0; c < 3; c++) begin
      shift_word($urandom & 32'hFFFFFF, W);
      latch(NC'(1 << c));
    end
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check_eq("midrst.shift_q", 32'(shift_q), 32'd0);
    check_eq("midrst.store_q", 32'(store_q), 32'd0);
    check_eq("midrst.outs", {28'd0, display_on, frame_done, err_onehot, err_count}, 32'd0);
    check_eq("midrst.state", 32'(dut.state_q), 32'(ST_IDLE));
    check_eq("midrst.col_mask", 32'(dut.col_mask), 32'd0);
    wait_cyc(1);
    reset = 1'b1;
    model_reset();
    wait_cyc(HOLD);
    check_state("midrst");
    for (int c = 3; c < NC; c++) begin
      shift_word($urandom & 32'hFFFFFF, W);
      latch(NC'(1 << c));
    end
    check_state("after_midrst");

    // Nominal frame.
    do_reset();
    for (int c = 0; c < NC; c++) begin
      shift_word(32'hA50F00 + 32'(c), W);
      latch(NC'(1 << c));
    end
    check_eq("nominal.done_count", 32'(done_seen), 32'd1);
    check_eq("nominal.rd7_const", 32'(m_frame[7]), 32'hA50F07);
    check_state("nominal");

    // Clear via reset_out.
    shift_word($urandom, 12);
    clear_link();
    shift_word(32'h123456, W);
    latch(NC'(1));
    check_eq("clear.store_q", 32'(store_q), 32'h123456);
    check_eq("clear.err_count", 32'(err_count), 32'd0);
    check_state("clear");

    // Coincident SH_CP and ST_CP rise after a full word.
    word = $urandom & 32'hFFFFFF;
    shift_word(word, W);
    col_select = NC'(1 << 4);
    DS = 1'b1;
    wait_cyc(HOLD);
    SH_CP = 1'b1;
    ST_CP = 1'b1;
    model_store(NC'(1 << 4));
    model_shift(1'b1);
    wait_cyc(HOLD);
    check_eq("coinc.store_q", 32'(store_q), word);
    check_eq("coinc.bit_cnt", 32'(dut.bit_cnt), 32'd1);
    SH_CP = 1'b0;
    ST_CP = 1'b0;
    wait_cyc(HOLD);
    check_state("coinc");

    // display_on follows OE after SYNC_STAGES cycles.
    OE = 1'b0;
    wait_cyc(SS - 1);
    check_eq("disp.early", 32'(display_on), 32'd0);
    wait_cyc(1);
    check_eq("disp.on", 32'(display_on), 32'd1);

    // Short word.
    clear_link();
    word = $urandom & 32'hFFFFFF;
    shift_word(word, W - 1);
    latch(NC'(1 << 2));
    check_eq("short.err_count", 32'(err_count), 32'd1);
    check_eq("short.store_q", 32'(store_q), word & 32'h7FFFFF);
    check_state("short");

    // Non-one-hot column select.
    shift_word($urandom & 32'hFFFFFF, W);
    latch(8'b0000_0110);
    check_eq("badcol.err_onehot", 32'(err_onehot), 32'd1);
    check_state("badcol");

    // Randomized traffic.
    do_reset();
    for (int k = 0; k < 24; k++) begin
      word = $urandom & 32'hFFFFFF;
      r = $urandom_range(0, 9);
      n = (r == 0) ? $urandom_range(20, 26) : W;
      col = (r == 1) ? NC'($urandom) : NC'(1 << $urandom_range(0, NC - 1));
      shift_word(word, n);
      latch(col);
      check_state($sformatf("rnd%0d", k));
    end

    wait_cyc(4);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rgb_matrix_shift_receiver.md
Name: rgb_matrix_shift_receiver

Overview:
- Receiving end of the serial LED-matrix link: the 74HC595-style shift-register chain and column drive on the 8x8 RGB board.
- Oversamples SH_CP/ST_CP/DS/OE/reset_out/col_select on the system clock, deserialises DS, and latches each stored word into a per-column frame buffer.
- Used as the board-side model in loopback/verification benches and as an on-FPGA frame monitor.
- Exposes a readback port, a frame-complete pulse and sticky protocol-error flags.

Parameters:
- SHIFT_W, 24, bits per column word (8 red + 8 green + 8 blue), MSB shifted first.
- COLS, 8, number of columns; also the width of col_select.
- SYNC_STAGES, 2, synchroniser depth on all link inputs (minimum 2).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- reset_out  in  1  shift-register clear from the transmitter, active-low.
- OE  in  1  output enable, active-low.
- SH_CP  in  1  shift clock, rising-edge active.
- ST_CP  in  1  storage clock, rising-edge active.
- DS  in  1  serial data.
- col_select  in  COLS  active column, one-hot, active-high.
- rd_col  in  $clog2(COLS)  readback column index.
- rd_data  out  SHIFT_W  frame word for rd_col, registered.
- shift_q  out  SHIFT_W  current shift-stage contents.
- store_q  out  SHIFT_W  current storage-stage contents.
- display_on  out  1  high when synchronised OE is low and reset_out is high.
- frame_done  out  1  one-cycle pulse when all COLS columns have been latched.
- err_onehot  out  1  sticky: col_select was not one-hot at an ST_CP edge.
- err_count  out  1  sticky: ST_CP edge arrived after a shift count other than SHIFT_W.

Behaviour:
- Reset (reset=0, async): all outputs, shift_q, store_q, frame buffer, bit counter, column mask and synchroniser flops go to 0. Flags clear only on reset.
- Synchronisation:
  - Every link input passes through SYNC_STAGES flops.
  - An edge counts as rising when the last synchronised sample is 1 and the previous one was 0.
  - Latency from a pin change to its effect is SYNC_STAGES+1 clk cycles.
  - The link is valid only if each SH_CP/ST_CP level lasts at least SYNC_STAGES+1 clk cycles. Shorter pulses give undefined behaviour.
- Clear: while synchronised reset_out=0, shift_q and bit_cnt are held at 0 and SH_CP edges are ignored. store_q is not affected (matches the 595).
- Shift on SH_CP rise: shift_q <= {shift_q[SHIFT_W-2:0], DS_sync}; bit_cnt saturates at SHIFT_W+1.
- Store on ST_CP rise:
  - store_q <= shift_q.
  - If bit_cnt != SHIFT_W, set err_count.
  - bit_cnt <= 0. shift_q is kept.
  - If col_select_sync is one-hot: frame[idx] <= shift_q and col_mask[idx] <= 1.
  - If col_select_sync is not one-hot: set err_onehot and leave the frame unchanged.
- Simultaneous SH_CP and ST_CP rise in the same cycle: the store captures the pre-shift shift_q, then the shift applies. The store's bit_cnt reset and the shift's increment together leave bit_cnt=1.
- Frame completion:
  - The frame-tracking FSM has states IDLE and COLLECT.
    - IDLE→COLLECT on the first valid latch.
    - COLLECT: accumulates col_mask.
  - When col_mask becomes all-ones, frame_done pulses for the cycle after the latch. col_mask then clears and the FSM returns to IDLE.
  - A re-latch of an already-set column inside COLLECT overwrites the data and does not count twice.
- Readback: rd_data <= frame[rd_col] every cycle (1-cycle latency). Reading a column latched in the same cycle returns the old value. rd_col >= COLS returns 0.
- display_on is a pure function of the synchronised flops, with no extra delay.

Decomposition:
- Package rgb_matrix_pkg:
  - SHIFT_W and COLS defaults.
  - Colour field offsets: RED=[23:16], GREEN=[15:8], BLUE=[7:0].
  - Typedef col_word_t.
  - Function onehot_to_idx (returns index and valid).
- Sub-module link_sync holds the SYNC_STAGES synchroniser plus rising-edge detector. It is instantiated once per control signal (SH_CP, ST_CP); the data and column inputs use plain sync only.

Test Plan:
- Reset mid-frame: latch 3 columns, assert reset=0 for 1 cycle. All outputs must read 0, the FSM must return to IDLE, and no frame_done may appear.
- Nominal frame: for col c=0..7, shift 24 bits of 24'hA5_0F_00+c (MSB first), then pulse ST_CP with col_select=1<<c. Exactly one frame_done must follow, with rd_data[c]=24'hA5_0F_00+c and both error flags at 0.
- Short word: shift 23 bits, then ST_CP. err_count must be 1 and store_q must equal the 23-bit value zero-extended.
- Bad column: col_select=8'b0000_0110 at ST_CP. err_onehot must be 1, the frame must be unchanged and col_mask must be unchanged.
- Clear: shift 12 bits, drop reset_out for 4 cycles, raise it, shift 24'h123456 and latch. store_q must be 24'h123456 and err_count must be 0.
- Coincident edges: SH_CP and ST_CP rise together after 24 shifts. store_q must be the pre-shift word and bit_cnt must be 1. OE=0 with reset_out=1 must give display_on=1 after SYNC_STAGES cycles.
